// File: rtl/pipeline_regfile_pkg.sv
// Shared register-file definitions: index width, register count, r0 encoding.
package pipeline_defs;
  localparam int REG_IDX_W = 5;
  localparam int NUM_GPR   = 32;
  localparam int NUM_RD    = 2;
  typedef logic [REG_IDX_W-1:0] ridx_t;
  localparam ridx_t REG_ZERO = 5'd0;
endpackage

// File: rtl/pipeline_regfile_if.sv
// Regfetch read ports, writeback port and issue claim port of the register file.
interface pipeline_regfile_if #(parameter int DATA_W = 32);
  import pipeline_defs::*;
  ridx_t             rindex0, rindex1, windex, claim_index;
  logic [DATA_W-1:0] rout0, rout1, wdata;
  logic              pending0, pending1, we, claim_en;

  modport master (
    output rindex0, rindex1, we, windex, wdata, claim_en, claim_index,
    input  rout0, rout1, pending0, pending1
  );
  modport slave (
    input  rindex0, rindex1, we, windex, wdata, claim_en, claim_index,
    output rout0, rout1, pending0, pending1
  );
endinterface

// File: rtl/pipeline_regfile_scoreboard.sv
// Per-register pending bits: writeback retires, claim sets (claim wins on the same index).
module regfile_scoreboard
  import pipeline_defs::*;
#(
  parameter int BYPASS = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  ridx_t                  windex,
  input  logic                   claim_en,
  input  ridx_t                  claim_index,
  input  ridx_t [NUM_RD-1:0]     rindex,
  output logic  [NUM_RD-1:0]     pending
);
  logic [NUM_GPR-1:0] pend_q, pend_d;

  always_comb begin
    pend_d = pend_q;
    if (we)       pend_d[windex]      = 1'b0;
    if (claim_en) pend_d[claim_index] = 1'b1;
    pend_d[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend_q <= '0;
    else     pend_q <= pend_d;
  end

  // An in-flight writeback already satisfies the reader unless a new producer claims it.
  for (genvar p = 0; p < NUM_RD; p++) begin : g_look
    logic fwd;
    assign fwd = (BYPASS != 0) && we && (windex == rindex[p]) &&
                 !(claim_en && (claim_index == windex));
    assign pending[p] = !rst && pend_q[rindex[p]] && !fwd;
  end
endmodule

// File: rtl/pipeline_regfile.sv
// Two-read/one-write GPR file with r0 hardwired to zero, optional write bypass and pending scoreboard.
module pipeline_regfile
  import pipeline_defs::*;
#(
  parameter int DATA_W = 32,
  parameter int BYPASS = 1
) (
  input  logic               clk,
  input  logic               rst,
  pipeline_regfile_if.slave  rf
);
  logic [DATA_W-1:0]              regs [NUM_GPR];
  ridx_t [NUM_RD-1:0]             rindex;
  logic  [NUM_RD-1:0][DATA_W-1:0] rout;
  logic  [NUM_RD-1:0]             pending;

  assign rindex  = {rf.rindex1, rf.rindex0};
  assign regs[0] = '0;

  for (genvar g = 1; g < NUM_GPR; g++) begin : g_reg
    logic [DATA_W-1:0] q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                                     q <= '0;
      else if (rf.we && rf.windex == ridx_t'(g))   q <= rf.wdata;
    end
    assign regs[g] = q;
  end

  // Reset forces the read side to zero so stale forwarded data never leaks out.
  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [DATA_W-1:0] d;
    always_comb begin
      d = '0;
      if (!rst && rindex[p] != REG_ZERO) begin
        if ((BYPASS != 0) && rf.we && rf.windex == rindex[p]) d = rf.wdata;
        else                                                   d = regs[rindex[p]];
      end
    end
    assign rout[p] = d;
  end

  regfile_scoreboard #(.BYPASS(BYPASS)) u_sb (
    .clk         (clk),
    .rst         (rst),
    .we          (rf.we),
    .windex      (rf.windex),
    .claim_en    (rf.claim_en),
    .claim_index (rf.claim_index),
    .rindex      (rindex),
    .pending     (pending)
  );

  assign rf.rout0    = rout[0];
  assign rf.rout1    = rout[1];
  assign rf.pending0 = pending[0];
  assign rf.pending1 = pending[1];
endmodule
